// File: rtl/boolean_response_checker.sv
// boolean_response_checker: checks an observed 2-input DUT against a truth table, with settle timing, coverage and protocol checks
module boolean_response_checker #(
  parameter logic [3:0] EXP_TT = 4'b0110,
  parameter int         SETTLE = 2,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  input  logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov_mask,
  output logic             proto_err
);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SETTLE, S_CHECK, S_DONE} state_t;
  localparam logic [3:0] LOAD = 4'(SETTLE - 1);
  state_t     state;
  logic [3:0] cnt;
  logic [1:0] idx_q;
  logic [1:0] ab;
  logic [3:0] cov_next;
  logic       miss;
  assign ab       = {a, b};
  assign cov_next = cov_mask | (4'b0001 << idx_q);
  assign miss     = y != EXP_TT[idx_q];
  assign busy     = state == S_ARMED || state == S_SETTLE || state == S_CHECK;
  assign done     = state == S_DONE;
  assign pass     = done && err_cnt == '0 && !proto_err;
  // y is sampled on the edge that enters CHECK, so the mismatch pulse is visible
  // during CHECK exactly SETTLE cycles after the vec_valid edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      cov_mask  <= '0;
      proto_err <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (start) begin
        err_cnt   <= '0;
        cov_mask  <= '0;
        proto_err <= 1'b0;
        state     <= S_ARMED;
      end else begin
        case (state)
          S_ARMED: if (vec_valid) begin
            idx_q <= ab;
            cnt   <= LOAD;
            state <= S_SETTLE;
          end
          S_SETTLE: if (vec_valid) begin
            idx_q <= ab;
            cnt   <= LOAD;
          end else if (ab != idx_q) begin
            proto_err <= 1'b1;
            state     <= S_ARMED;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mismatch <= miss;
            err_cnt  <= miss && err_cnt != '1 ? err_cnt + CNT_W'(1) : err_cnt;
            cov_mask <= cov_next;
            state    <= S_CHECK;
          end
          S_CHECK: state <= cov_mask == 4'hF ? S_DONE : S_ARMED;
          default: ;
        endcase
      end
    end
  end
endmodule
